fir_xifu_wb: RTL and testbench

// Writeback stage of the FIR XIFU, directly downstream of the EX stage. Buffers in-flight

---
 rtl/fir_xifu_wb.sv | 198 +++++++++++++++++++
 tb/tb_fir_xifu_wb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb -- writeback stage of the FIR XIFU.
//
// Holds LDTAP / LDSAM / STSAM ops handed over by EX in an in-order buffer
// until the XIF commit and the memory result have both arrived. Each op then
// returns its post-incremented address to the core's rd through the XIF
// result handshake. When the op retires, load data is routed into the tap
// register file (LDTAP) or pushed into the sample delay line (LDSAM).
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   ex_valid_i / ex_ready_o         op hand-over from EX (id, op, rd, next_addr)
//   commit_valid_i/_id_i/_kill_i    XIF commit or kill of an in-flight id
//   mem_result_valid_i/_id_i/_rdata_i  XIF memory result for an in-flight id
//   result_valid_o / result_ready_i writeback to the core (id, rd, data)
//   tap_we_o, tap_idx_o, tap_data_o one-cycle tap register write
//   sample_we_o, sample_data_o      one-cycle sample delay-line push
//   err_o                           sticky memory-result protocol error
module fir_xifu_wb #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int NTAPS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ex_valid_i,
    output logic                     ex_ready_o,
    input  logic [ID_W-1:0]          ex_id_i,
    input  logic [1:0]               ex_op_i,
    input  logic [4:0]               ex_rd_i,
    input  logic [31:0]              ex_next_addr_i,
    input  logic                     commit_valid_i,
    input  logic [ID_W-1:0]          commit_id_i,
    input  logic                     commit_kill_i,
    input  logic                     mem_result_valid_i,
    input  logic [ID_W-1:0]          mem_result_id_i,
    input  logic [31:0]              mem_result_rdata_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_W-1:0]          result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [31:0]              result_data_o,
    output logic                     tap_we_o,
    output logic [$clog2(NTAPS)-1:0] tap_idx_o,
    output logic [31:0]              tap_data_o,
    output logic                     sample_we_o,
    output logic [31:0]              sample_data_o,
    output logic                     err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(NTAPS);

    localparam logic [1:0] OP_LDTAP = 2'b00;
    localparam logic [1:0] OP_LDSAM = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Per-entry storage
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_committed;
    logic [DEPTH-1:0] ent_killed;
    logic [DEPTH-1:0] ent_mem_done;
    logic [ID_W-1:0]  ent_id        [DEPTH];
    logic [1:0]       ent_op        [DEPTH];
    logic [4:0]       ent_rd        [DEPTH];
    logic [31:0]      ent_next_addr [DEPTH];
    logic [31:0]      ent_rdata     [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_next;
    logic          ready_q;
    logic [TW-1:0] tap_idx_q;
    logic          err_q;

    logic             push;
    logic             pop;
    logic             head_live;
    logic             kill_pop;
    logic             handshake;
    logic             mem_err;
    logic [DEPTH-1:0] push_sel;
    logic [DEPTH-1:0] slot_live;
    logic [DEPTH-1:0] commit_hit;
    logic [DEPTH-1:0] mem_hit;
    logic [DEPTH-1:0] mem_dup;
    logic [ID_W-1:0]  slot_id [DEPTH];

    assign push = ex_valid_i & ready_q;

    // A slot being written this cycle already takes part in id matching, so a
    // commit (or memory result) arriving together with the push is not lost.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            push_sel[i]   = push & (wr_ptr_q == PW'(i));
            slot_live[i]  = ent_valid[i] | push_sel[i];
            slot_id[i]    = push_sel[i] ? ex_id_i : ent_id[i];
            commit_hit[i] = commit_valid_i & slot_live[i] & (slot_id[i] == commit_id_i);
            mem_hit[i]    = mem_result_valid_i & slot_live[i] & (slot_id[i] == mem_result_id_i);
            // Stale mem_done of a freshly pushed slot must not count as a duplicate.
            mem_dup[i]    = mem_hit[i] & ent_mem_done[i] & ~push_sel[i];
        end
    end

    assign mem_err = mem_result_valid_i & (~(|mem_hit) | (|mem_dup));

    // Head retirement; gated by rst_i so nothing escapes during a reset cycle.
    assign head_live      = ent_valid[rd_ptr_q] & ~rst_i;
    assign kill_pop       = head_live & ent_killed[rd_ptr_q];
    assign result_valid_o = head_live & ~ent_killed[rd_ptr_q]
                          & ent_committed[rd_ptr_q] & ent_mem_done[rd_ptr_q];
    assign handshake      = result_valid_o & result_ready_i;
    assign pop            = kill_pop | handshake;

    assign result_id_o   = result_valid_o ? ent_id[rd_ptr_q]        : '0;
    assign result_rd_o   = result_valid_o ? ent_rd[rd_ptr_q]        : '0;
    assign result_data_o = result_valid_o ? ent_next_addr[rd_ptr_q] : '0;

    assign tap_we_o      = handshake & (ent_op[rd_ptr_q] == OP_LDTAP);
    assign tap_idx_o     = tap_we_o ? tap_idx_q : '0;
    assign tap_data_o    = tap_we_o ? ent_rdata[rd_ptr_q] : '0;
    assign sample_we_o   = handshake & (ent_op[rd_ptr_q] == OP_LDSAM);
    assign sample_data_o = sample_we_o ? ent_rdata[rd_ptr_q] : '0;

    assign ex_ready_o = ready_q;
    assign err_o      = err_q;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + (PW+1)'(1);
            2'b01:   count_next = count_q - (PW+1)'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            tap_idx_q     <= '0;
            err_q         <= 1'b0;
            ent_valid     <= '0;
            ent_committed <= '0;
            ent_killed    <= '0;
            ent_mem_done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id[i]        <= '0;
                ent_op[i]        <= '0;
                ent_rd[i]        <= '0;
                ent_next_addr[i] <= '0;
                ent_rdata[i]     <= '0;
            end
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_next;
            // Ready is a flop of the post-update occupancy: a pop does not
            // open the buffer for a same-cycle push.
            ready_q <= (count_next < (PW+1)'(DEPTH));
            if (tap_we_o) begin
                tap_idx_q <= (tap_idx_q == TW'(NTAPS-1)) ? '0 : tap_idx_q + TW'(1);
            end
            err_q <= err_q | mem_err;

            for (int i = 0; i < DEPTH; i++) begin
                if (pop && (rd_ptr_q == PW'(i))) begin
                    ent_valid[i] <= 1'b0;
                end
                if (push_sel[i]) begin
                    ent_valid[i]     <= 1'b1;
                    ent_id[i]        <= ex_id_i;
                    ent_op[i]        <= ex_op_i;
                    ent_rd[i]        <= ex_rd_i;
                    ent_next_addr[i] <= ex_next_addr_i;
                    ent_rdata[i]     <= '0;
                    ent_committed[i] <= 1'b0;
                    ent_killed[i]    <= (ex_op_i == OP_RSVD);
                    ent_mem_done[i]  <= 1'b0;
                end
                // Flag updates come after the push defaults so they win.
                if (commit_hit[i]) begin
                    if (commit_kill_i) ent_killed[i]    <= 1'b1;
                    else               ent_committed[i] <= 1'b1;
                end
                // A duplicate result flags an error but never disturbs data
                // that may already be presented on the result port.
                if (mem_hit[i] && !mem_dup[i]) begin
                    ent_mem_done[i] <= 1'b1;
                    ent_rdata[i]    <= mem_result_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Testbench for fir_xifu_wb: a vector table, hand-written corner sequences
// and a randomized run, all compared against a queue-based reference model.
module tb_fir_xifu_wb;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int NTAPS = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [3:0]  ex_id_i;
    logic [1:0]  ex_op_i;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_next_addr_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        mem_result_valid_i;
    logic [3:0]  mem_result_id_i;
    logic [31:0] mem_result_rdata_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        tap_we_o;
    logic [2:0]  tap_idx_o;
    logic [31:0] tap_data_o;
    logic        sample_we_o;
    logic [31:0] sample_data_o;
    logic        err_o;

    fir_xifu_wb #(.DEPTH(DEPTH), .ID_W(ID_W), .NTAPS(NTAPS)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ex_valid_i         (ex_valid_i),
        .ex_ready_o         (ex_ready_o),
        .ex_id_i            (ex_id_i),
        .ex_op_i            (ex_op_i),
        .ex_rd_i            (ex_rd_i),
        .ex_next_addr_i     (ex_next_addr_i),
        .commit_valid_i     (commit_valid_i),
        .commit_id_i        (commit_id_i),
        .commit_kill_i      (commit_kill_i),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_result_id_i    (mem_result_id_i),
        .mem_result_rdata_i (mem_result_rdata_i),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
        .result_id_o        (result_id_o),
        .result_rd_o        (result_rd_o),
        .result_data_o      (result_data_o),
        .tap_we_o           (tap_we_o),
        .tap_idx_o          (tap_idx_o),
        .tap_data_o         (tap_data_o),
        .sample_we_o        (sample_we_o),
        .sample_data_o      (sample_data_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: one queue element per in-flight op, oldest first.
    typedef struct {
        logic [3:0]  id;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] nxt;
        bit          cm;
        bit          kl;
        bit          dn;
        logic [31:0] rdata;
    } ent_t;

    ent_t mq[$];
    int   tap_m = 0;
    bit   err_m = 1'b0;

    typedef struct {
        int ev, eid, eop, erd, enx;
        int cv, cid, ck;
        int mv, mid, md;
        int rr;
        int x_rdy, x_rv, x_id, x_rd, x_dat, x_tw, x_ti, x_td, x_sw, x_sd, x_err;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        ex_valid_i         = 1'b0;
        commit_valid_i     = 1'b0;
        commit_kill_i      = 1'b0;
        mem_result_valid_i = 1'b0;
        result_ready_i     = 1'b1;
    endtask

    task automatic push_in(input int id, input int op, input int rd, input int nx);
        ex_valid_i     = 1'b1;
        ex_id_i        = 4'(id);
        ex_op_i        = 2'(op);
        ex_rd_i        = 5'(rd);
        ex_next_addr_i = 32'(nx);
    endtask

    task automatic cmt_in(input int id, input bit kill);
        commit_valid_i = 1'b1;
        commit_id_i    = 4'(id);
        commit_kill_i  = kill;
    endtask

    task automatic mem_in(input int id, input int d);
        mem_result_valid_i = 1'b1;
        mem_result_id_i    = 4'(id);
        mem_result_rdata_i = 32'(d);
    endtask

    // One clock cycle: compare outputs against the model, clock, update model.
    // Called just after a falling edge with the cycle's inputs already driven.
    task automatic step();
        bit   e_rv, e_hs, do_pop, push_m, hit, bad;
        ent_t h, ne, t;
        #1;
        h      = '{default: '0};
        e_rv   = !rst_i && mq.size() > 0 && !mq[0].kl && mq[0].cm && mq[0].dn;
        e_hs   = e_rv && result_ready_i;
        if (mq.size() > 0) h = mq[0];
        if (chk_en) begin
            chk("ex_ready", 32'(ex_ready_o), 32'(mq.size() < DEPTH));
            chk("result_valid", 32'(result_valid_o), 32'(e_rv));
            if (e_rv) begin
                chk("result_id", 32'(result_id_o), 32'(h.id));
                chk("result_rd", 32'(result_rd_o), 32'(h.rd));
                chk("result_data", result_data_o, h.nxt);
            end
            chk("tap_we", 32'(tap_we_o), 32'(e_hs && h.op == 2'd0));
            if (e_hs && h.op == 2'd0) begin
                chk("tap_idx", 32'(tap_idx_o), 32'(tap_m));
                chk("tap_data", tap_data_o, h.rdata);
            end
            chk("sample_we", 32'(sample_we_o), 32'(e_hs && h.op == 2'd1));
            if (e_hs && h.op == 2'd1) chk("sample_data", sample_data_o, h.rdata);
            chk("err", 32'(err_o), 32'(err_m));
        end
        @(posedge clk_i);
        if (rst_i) begin
            mq.delete();
            tap_m = 0;
            err_m = 1'b0;
        end else begin
            do_pop = mq.size() > 0 && (mq[0].kl || e_hs);
            if (e_hs && h.op == 2'd0) tap_m = (tap_m + 1) % NTAPS;
            push_m = ex_valid_i && mq.size() < DEPTH;
            ne = '{id: ex_id_i, op: ex_op_i, rd: ex_rd_i, nxt: ex_next_addr_i,
                   cm: 1'b0, kl: (ex_op_i == 2'd3), dn: 1'b0, rdata: '0};
            hit = 1'b0;
            bad = 1'b0;
            for (int i = 0; i < mq.size(); i++) begin
                t = mq[i];
                if (commit_valid_i && t.id == commit_id_i) begin
                    if (commit_kill_i) t.kl = 1'b1; else t.cm = 1'b1;
                end
                if (mem_result_valid_i && t.id == mem_result_id_i) begin
                    hit = 1'b1;
                    if (t.dn) bad = 1'b1;
                    else begin t.dn = 1'b1; t.rdata = mem_result_rdata_i; end
                end
                mq[i] = t;
            end
            if (push_m) begin
                if (commit_valid_i && ne.id == commit_id_i) begin
                    if (commit_kill_i) ne.kl = 1'b1; else ne.cm = 1'b1;
                end
                if (mem_result_valid_i && ne.id == mem_result_id_i) begin
                    hit = 1'b1;
                    ne.dn = 1'b1;
                    ne.rdata = mem_result_rdata_i;
                end
            end
            if (mem_result_valid_i && (!hit || bad)) err_m = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (push_m) mq.push_back(ne);
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    int next_id;
    int cand[$];
    int j;
    bit acc;

    initial begin
        rst_i              = 1'b1;
        ex_id_i            = '0;
        ex_op_i            = '0;
        ex_rd_i            = '0;
        ex_next_addr_i     = '0;
        commit_id_i        = '0;
        mem_result_id_i    = '0;
        mem_result_rdata_i = '0;
        idle();
        @(negedge clk_i);
        step();
        step();
        chk_en = 1'b1;
        rst_i  = 1'b0;

        // Reset state
        idle();
        #1;
        chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
        chk("rst_result_valid", 32'(result_valid_o), 32'd0);
        chk("rst_result_id", 32'(result_id_o), 32'd0);
        chk("rst_result_rd", 32'(result_rd_o), 32'd0);
        chk("rst_result_data", result_data_o, 32'd0);
        chk("rst_tap_we", 32'(tap_we_o), 32'd0);
        chk("rst_tap_idx", 32'(tap_idx_o), 32'd0);
        chk("rst_tap_data", tap_data_o, 32'd0);
        chk("rst_sample_we", 32'(sample_we_o), 32'd0);
        chk("rst_sample_data", sample_data_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        step();

        // Vector table: LDTAP basic flow, STSAM mem-before-commit, LDSAM commit-with-push
        //         ev eid eop erd enx     cv cid ck mv mid md       rr  rdy rv id rd dat     tw ti td       sw sd       err
        vt[0]  = '{1, 3, 0, 5, 'h104,  0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[1]  = '{0, 0, 0, 0, 0,      1, 3, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[2]  = '{0, 0, 0, 0, 0,      0, 0, 0, 1, 3, 'hAAAA,   1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[3]  = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        0,  1, 1, 3, 5, 'h104,  0, 0, 0,       0, 0,       0};
        vt[4]  = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 1, 3, 5, 'h104,  1, 0, 'hAAAA,  0, 0,       0};
        vt[5]  = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[6]  = '{1, 1, 2, 7, 'h200,  0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[7]  = '{0, 0, 0, 0, 0,      0, 0, 0, 1, 1, 'h55,     1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[8]  = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[9]  = '{0, 0, 0, 0, 0,      1, 1, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[10] = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 1, 1, 7, 'h200,  0, 0, 0,       0, 0,       0};
        vt[11] = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[12] = '{1, 6, 1, 9, 'h300,  1, 6, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[13] = '{0, 0, 0, 0, 0,      0, 0, 0, 1, 6, 'h1234,   1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};
        vt[14] = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 1, 6, 9, 'h300,  0, 0, 0,       1, 'h1234,  0};
        vt[15] = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,        1,  1, 0, 0, 0, 0,      0, 0, 0,       0, 0,       0};

        for (int r = 0; r < 16; r++) begin
            idle();
            if (vt[r].ev != 0) push_in(vt[r].eid, vt[r].eop, vt[r].erd, vt[r].enx);
            if (vt[r].cv != 0) cmt_in(vt[r].cid, vt[r].ck != 0);
            if (vt[r].mv != 0) mem_in(vt[r].mid, vt[r].md);
            result_ready_i = (vt[r].rr != 0);
            #1;
            chk("tbl_ex_ready", 32'(ex_ready_o), 32'(vt[r].x_rdy));
            chk("tbl_result_valid", 32'(result_valid_o), 32'(vt[r].x_rv));
            if (vt[r].x_rv != 0) begin
                chk("tbl_result_id", 32'(result_id_o), 32'(vt[r].x_id));
                chk("tbl_result_rd", 32'(result_rd_o), 32'(vt[r].x_rd));
                chk("tbl_result_data", result_data_o, 32'(vt[r].x_dat));
            end
            chk("tbl_tap_we", 32'(tap_we_o), 32'(vt[r].x_tw));
            if (vt[r].x_tw != 0) begin
                chk("tbl_tap_idx", 32'(tap_idx_o), 32'(vt[r].x_ti));
                chk("tbl_tap_data", tap_data_o, 32'(vt[r].x_td));
            end
            chk("tbl_sample_we", 32'(sample_we_o), 32'(vt[r].x_sw));
            if (vt[r].x_sw != 0) chk("tbl_sample_data", sample_data_o, 32'(vt[r].x_sd));
            chk("tbl_err", 32'(err_o), 32'(vt[r].x_err));
            step();
        end

        // Killed head is dropped silently, the committed op behind it follows
        do_reset();
        idle(); push_in(2, 0, 4, 'h400); step();
        idle(); push_in(3, 1, 6, 'h404); cmt_in(3, 1'b0); step();
        idle(); mem_in(3, 'hBEEF); step();
        idle(); mem_in(2, 'h1111); step();
        idle(); cmt_in(2, 1'b1); #1 chk("kill_rv_pre", 32'(result_valid_o), 32'd0); step();
        idle(); #1;
        chk("kill_rv_drop", 32'(result_valid_o), 32'd0);
        chk("kill_tap_we", 32'(tap_we_o), 32'd0);
        step();
        idle(); #1;
        chk("kill_next_rv", 32'(result_valid_o), 32'd1);
        chk("kill_next_id", 32'(result_id_o), 32'd3);
        chk("kill_next_sample", sample_data_o, 32'hBEEF);
        step();
        idle(); step();

        // Result held stable while the core stalls
        idle(); push_in(5, 1, 11, 'h500); cmt_in(5, 1'b0); step();
        idle(); mem_in(5, 'hC0DE); step();
        for (int k = 0; k < 3; k++) begin
            idle(); result_ready_i = 1'b0; #1;
            chk("hold_rv", 32'(result_valid_o), 32'd1);
            chk("hold_id", 32'(result_id_o), 32'd5);
            chk("hold_rd", 32'(result_rd_o), 32'd11);
            chk("hold_data", result_data_o, 32'h500);
            chk("hold_sample_we", 32'(sample_we_o), 32'd0);
            step();
        end
        idle(); #1;
        chk("hold_release_we", 32'(sample_we_o), 32'd1);
        chk("hold_release_data", sample_data_o, 32'hC0DE);
        step();
        idle(); step();

        // Fill the buffer with ex_valid held, retire one, refill
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(); push_in(k, 0, k + 1, 16 * k); step();
        end
        idle(); push_in(4, 0, 5, 'h40); cmt_in(0, 1'b0); #1 chk("full_ready", 32'(ex_ready_o), 32'd0); step();
        idle(); push_in(4, 0, 5, 'h40); mem_in(0, 'h100); #1 chk("full_ready2", 32'(ex_ready_o), 32'd0); step();
        idle(); push_in(4, 0, 5, 'h40); #1;
        chk("full_pop_rv", 32'(result_valid_o), 32'd1);
        chk("full_pop_ready", 32'(ex_ready_o), 32'd0);
        step();
        idle(); push_in(4, 0, 5, 'h40); #1 chk("ready_after_pop", 32'(ex_ready_o), 32'd1); step();
        idle(); #1 chk("refull_ready", 32'(ex_ready_o), 32'd0); step();
        for (int k = 1; k < 5; k++) begin
            idle(); cmt_in(k, 1'b0); mem_in(k, 'h100 + k); step();
        end
        repeat (6) begin idle(); step(); end

        // Tap index wraps after NTAPS writes
        do_reset();
        for (int k = 0; k < 9; k++) begin
            idle(); push_in(k, 0, 1, 'h600 + 4 * k); cmt_in(k, 1'b0); step();
            idle(); mem_in(k, 'hD0 + k); step();
            idle(); #1;
            chk("wrap_tap_we", 32'(tap_we_o), 32'd1);
            chk("wrap_tap_idx", 32'(tap_idx_o), 32'(k % NTAPS));
            step();
        end

        // Memory result with an unknown id sets a sticky error
        idle(); mem_in(15, 'h0); #1 chk("err_before", 32'(err_o), 32'd0); step();
        idle(); #1 chk("err_set", 32'(err_o), 32'd1); step();
        repeat (3) begin idle(); step(); end
        idle(); #1 chk("err_sticky", 32'(err_o), 32'd1); step();

        // Reset with two retire-ready entries in flight
        idle(); push_in(1, 0, 3, 'h10); cmt_in(1, 1'b0); step();
        idle(); push_in(2, 1, 4, 'h20); cmt_in(2, 1'b0); mem_in(1, 'h77); result_ready_i = 1'b0; step();
        idle(); mem_in(2, 'h88); result_ready_i = 1'b0; step();
        idle(); result_ready_i = 1'b0; #1 chk("prerst_rv", 32'(result_valid_o), 32'd1); step();
        idle(); rst_i = 1'b1; #1;
        chk("inrst_rv", 32'(result_valid_o), 32'd0);
        chk("inrst_tap_we", 32'(tap_we_o), 32'd0);
        chk("inrst_sample_we", 32'(sample_we_o), 32'd0);
        step();
        rst_i = 1'b0;
        idle(); #1;
        chk("postrst_ready", 32'(ex_ready_o), 32'd1);
        chk("postrst_rv", 32'(result_valid_o), 32'd0);
        chk("postrst_data", result_data_o, 32'd0);
        chk("postrst_tap_idx", 32'(tap_idx_o), 32'd0);
        chk("postrst_err", 32'(err_o), 32'd0);
        step();
        repeat (3) begin idle(); step(); end

        // Randomized traffic against the model
        do_reset();
        next_id = 0;
        for (int c = 0; c < 600; c++) begin
            idle();
            ex_valid_i     = ($urandom_range(0, 2) != 0);
            ex_id_i        = 4'(next_id);
            ex_op_i        = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ex_rd_i        = 5'($urandom);
            ex_next_addr_i = $urandom;

            cand.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].cm && !mq[i].kl) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                j = cand[$urandom_range(0, cand.size() - 1)];
                cmt_in(int'(mq[j].id), $urandom_range(0, 4) == 0);
            end else if ($urandom_range(0, 9) == 0) begin
                cmt_in(next_id + 8, $urandom_range(0, 1) == 1);
            end

            cand.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].dn) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                j = cand[$urandom_range(0, cand.size() - 1)];
                mem_in(int'(mq[j].id), int'($urandom));
            end
            if (c == 500) mem_in(next_id + 8, 'h5A5A);

            result_ready_i = ($urandom_range(0, 3) != 0);
            acc = ex_valid_i && mq.size() < DEPTH;
            step();
            if (acc) next_id = (next_id + 1) % 16;
        end
        idle(); #1 chk("rand_err_sticky", 32'(err_o), 32'd1); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
